// File: rtl/mipi_tx_pkg.sv
// Shared constants and types for the MIPI CSI-2 RAW8/RAW10 transmit packer.
// Mode encoding, buffer depth, FSM states and per-mode group sizes live here.
package mipi_tx_pkg;

  localparam logic RAW8  = 1'b0;
  localparam logic RAW10 = 1'b1;

  localparam int BUF_BYTES = 8;

  localparam logic [3:0] BPG_RAW8  = 4'd4;
  localparam logic [3:0] BPG_RAW10 = 4'd5;

  typedef enum logic {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } state_t;

  function automatic logic [3:0] bytes_per_group(input logic mode);
    return (mode == RAW10) ? BPG_RAW10 : BPG_RAW8;
  endfunction

endpackage

// File: rtl/mipi_raw_group_formatter.sv
// Combinational formatter: one group of four 10-bit pixels -> 4 (RAW8) or 5 (RAW10) bytes.
// Byte 0 sits in bytes_o[7:0]; the RAW10 LSB byte is byte 4.
module mipi_raw_group_formatter
  import mipi_tx_pkg::*;
(
  input  logic [39:0] pixels_i,
  input  logic        mode_i,
  output logic [39:0] bytes_o,
  output logic [3:0]  nbytes_o
);

  always_comb begin
    bytes_o        = '0;
    bytes_o[7:0]   = pixels_i[9:2];
    bytes_o[15:8]  = pixels_i[19:12];
    bytes_o[23:16] = pixels_i[29:22];
    bytes_o[31:24] = pixels_i[39:32];
    // RAW10 fifth byte collects the two LSBs of each pixel, P0 in the low bits
    if (mode_i == RAW10) begin
      bytes_o[39:32] = {pixels_i[31:30], pixels_i[21:20], pixels_i[11:10], pixels_i[1:0]};
    end
    nbytes_o = bytes_per_group(mode_i);
  end

endmodule

// File: rtl/mipi_tx_raw_packer.sv
// RAW8/RAW10 line packer: formats pixel groups into bytes, buffers up to 8 bytes,
// and emits 32-bit words oldest-byte-first, zero-padding the final word of a line.
module mipi_tx_raw_packer
  import mipi_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mode_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [39:0] in_pixels_i,
  input  logic        in_last_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o
);

  // Handshake: a transfer happens on a rising clk_i edge where valid & ready are
  // both high; valid never depends on ready, in_ready_o depends on out_ready_i.

  state_t                   r_state;
  logic [3:0]               r_count;
  logic [8*BUF_BYTES-1:0]   r_buf;
  logic                     r_mode;
  logic                     r_in_line;

  logic                     w_mode;
  logic [39:0]              w_bytes;
  logic [3:0]               w_nbytes;
  logic                     w_pop;
  logic                     w_push;
  logic [3:0]               w_base;
  logic [4:0]               w_fill;
  logic [3:0]               w_count_next;
  logic [8*BUF_BYTES-1:0]   w_buf_next;

  // First group of a line uses the live mode pin; later groups use the latched one
  assign w_mode = r_in_line ? r_mode : mode_i;

  mipi_raw_group_formatter u_fmt (
    .pixels_i (in_pixels_i),
    .mode_i   (w_mode),
    .bytes_o  (w_bytes),
    .nbytes_o (w_nbytes)
  );

  assign out_valid_o = (r_count >= 4'd4) || ((r_state == FLUSH) && (r_count != 4'd0));
  assign out_last_o  = (r_state == FLUSH) && (r_count != 4'd0) && (r_count <= 4'd4);
  assign out_data_o  = r_buf[31:0];

  assign w_pop  = out_valid_o & out_ready_i;
  assign w_base = w_pop ? ((r_count > 4'd4) ? (r_count - 4'd4) : 4'd0) : r_count;
  assign w_fill = {1'b0, w_base} + {1'b0, w_nbytes};

  assign in_ready_o   = (r_state == STREAM) && (w_fill <= 5'd8);
  assign w_push       = in_valid_i & in_ready_o;
  assign w_count_next = w_push ? w_fill[3:0] : w_base;

  // Bytes above the count are always zero, so a short flush word pads itself
  always_comb begin
    w_buf_next = w_pop ? {32'h0, r_buf[63:32]} : r_buf;
    for (int i = 0; i < BUF_BYTES; i++) begin
      for (int j = 0; j < 5; j++) begin
        if (w_push && (4'(j) < w_nbytes) && (4'(i) == (w_base + 4'(j)))) begin
          w_buf_next[8*i +: 8] = w_bytes[8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= STREAM;
      r_count   <= 4'd0;
      r_buf     <= '0;
      r_mode    <= RAW10;
      r_in_line <= 1'b0;
    end else begin
      r_buf   <= w_buf_next;
      r_count <= w_count_next;
      if (w_push) begin
        if (!r_in_line) begin
          r_mode <= mode_i;
        end
        r_in_line <= !in_last_i;
      end
      case (r_state)
        STREAM: if (w_push && in_last_i) r_state <= FLUSH;
        FLUSH:  if (w_count_next == 4'd0) r_state <= STREAM;
        default: r_state <= STREAM;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_tx_raw_packer.sv
// Bench for mipi_tx_raw_packer: directed line scenarios with fixed expected words,
// then random lines checked against a byte-stream reference model.
module tb_mipi_tx_raw_packer;

  logic        clk;
  logic        reset_i;
  logic        mode_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [39:0] in_pixels_i;
  logic        in_last_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        out_last_o;

  mipi_tx_raw_packer dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .mode_i      (mode_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_pixels_i (in_pixels_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];          // {last, data}
  logic [7:0]  mdl_bytes[$];
  bit          mdl_in_line = 0;
  logic        mdl_mode = 1'b1;
  int          ready_mode = 0;    // 0: always ready, 1: toggle, 2: random

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] make_px(input int p0, input int p1, input int p2, input int p3);
    logic [39:0] r;
    r[9:0]   = 10'(p0);
    r[19:10] = 10'(p1);
    r[29:20] = 10'(p2);
    r[39:30] = 10'(p3);
    return r;
  endfunction

  function automatic void model_push_word(input logic last);
    logic [32:0] w;
    w[7:0]   = mdl_bytes.pop_front();
    w[15:8]  = mdl_bytes.pop_front();
    w[23:16] = mdl_bytes.pop_front();
    w[31:24] = mdl_bytes.pop_front();
    w[32]    = last;
    exp_q.push_back(w);
  endfunction

  // Reference: line-level byte stream; words leave in groups of four, the line's
  // final word carries last and is zero padded to four bytes.
  function automatic void model_group(input logic [39:0] px, input logic md_in, input logic last);
    int low;
    if (!mdl_in_line) mdl_mode = md_in;
    mdl_in_line = !last;
    low = 0;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = int'(px[10*k +: 10]);
      mdl_bytes.push_back(8'(p / 4));
      low += (p % 4) << (2 * k);
    end
    if (mdl_mode == 1'b1) mdl_bytes.push_back(8'(low));
    while (mdl_bytes.size() > 4 || (mdl_bytes.size() == 4 && !last)) model_push_word(1'b0);
    if (last) begin
      while (mdl_bytes.size() < 4) mdl_bytes.push_back(8'h00);
      model_push_word(1'b1);
    end
  endfunction

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ~out_ready_i;
        default: out_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word;
  logic [32:0] mon_exp;

  always @(negedge clk) begin
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 40'(out_valid_o), 40'd1);
        check("hold_word", 40'({out_last_o, out_data_o}), 40'(prev_word));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got last=%0b data=%08h, no word expected", out_last_o, out_data_o);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 40'({out_last_o, out_data_o}), 40'(mon_exp));
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_word  = {out_last_o, out_data_o};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_group(input logic [39:0] px, input logic last, input logic md,
                            input bit track, output int waits);
    int  w;
    bit  done;
    w = 0;
    done = 0;
    in_valid_i  = 1'b1;
    in_pixels_i = px;
    in_last_i   = last;
    mode_i      = md;
    while (!done && w < 300) begin
      @(negedge clk);
      if (in_ready_o) begin
        done = 1;
        if (track) model_group(px, md, last);
      end else begin
        w++;
      end
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: group never accepted after %0d cycles", w);
    end
    waits = w;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid_o) && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(name, 40'(exp_q.size()), 40'd0);
    idle(3);
  endtask

  task automatic push_ref_line();
    exp_q.push_back({1'b0, 32'h55AA00FF});
    exp_q.push_back({1'b0, 32'hAA00FF63});
    exp_q.push_back({1'b0, 32'h00FF6355});
    exp_q.push_back({1'b0, 32'hFF6355AA});
    exp_q.push_back({1'b1, 32'h6355AA00});
  endtask

  task automatic send_ref_line(output int tot_waits);
    int w;
    tot_waits = 0;
    for (int g = 0; g < 4; g++) begin
      send_group(make_px(10'h3FF, 10'h000, 10'h2AA, 10'h155), (g == 3), 1'b1, 1'b0, w);
      tot_waits += w;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          waits;
    logic [39:0] px;
    logic        line_mode;
    int          ngroups;

    reset_i     = 1'b1;
    mode_i      = 1'b1;
    in_valid_i  = 1'b0;
    in_pixels_i = '0;
    in_last_i   = 1'b0;
    idle(3);
    reset_i = 1'b0;
    #1;
    check("rst_out_valid", 40'(out_valid_o), 40'd0);
    check("rst_out_last", 40'(out_last_o), 40'd0);
    check("rst_out_data", 40'(out_data_o), 40'd0);
    check("rst_in_ready", 40'(in_ready_o), 40'd1);
    idle(1);

    // RAW10 reference line, always ready
    ready_mode = 0;
    push_ref_line();
    send_ref_line(waits);
    check("raw10_full_rate", 40'(waits), 40'd0);
    drain("raw10_line_drain");

    // RAW10 single group with last: in_ready held low until the pad word pops
    exp_q.push_back({1'b0, 32'h55AA00FF});
    exp_q.push_back({1'b1, 32'h00000063});
    send_group(make_px(10'h3FF, 10'h000, 10'h2AA, 10'h155), 1'b1, 1'b1, 1'b0, waits);
    @(negedge clk);
    check("flush_ready_0a", 40'(in_ready_o), 40'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_ready_0b", 40'(in_ready_o), 40'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_ready_1", 40'(in_ready_o), 40'd1);
    @(posedge clk); #1;
    drain("single_drain");

    // RAW8: three groups back to back, one word each
    for (int g = 0; g < 3; g++) exp_q.push_back({(g == 2), 32'h408001FF});
    for (int g = 0; g < 3; g++) begin
      send_group(make_px(10'h3FC, 10'h004, 10'h200, 10'h100), (g == 2), 1'b0, 1'b0, waits);
      check("raw8_ready", 40'(waits), 40'd0);
    end
    drain("raw8_drain");

    // RAW10 with out_ready toggling every cycle
    ready_mode = 1;
    push_ref_line();
    send_ref_line(waits);
    drain("toggle_drain");

    // Reset mid-line, then a clean reference line
    ready_mode = 0;
    idle(1);
    exp_q.push_back({1'b0, 32'h55AA00FF});
    exp_q.push_back({1'b0, 32'hAA00FF63});
    send_group(make_px(10'h3FF, 10'h000, 10'h2AA, 10'h155), 1'b0, 1'b1, 1'b0, waits);
    send_group(make_px(10'h3FF, 10'h000, 10'h2AA, 10'h155), 1'b0, 1'b1, 1'b0, waits);
    reset_i = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 40'(out_valid_o), 40'd0);
    check("midrst_out_last", 40'(out_last_o), 40'd0);
    check("midrst_out_data", 40'(out_data_o), 40'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    idle(1);
    push_ref_line();
    send_ref_line(waits);
    drain("post_reset_drain");

    // Random lines: random mode per line, mode pin scrambled mid-line, random gaps
    for (int ln = 0; ln < 40; ln++) begin
      ready_mode = $urandom_range(0, 2);
      line_mode  = 1'($urandom);
      ngroups    = $urandom_range(1, 8);
      for (int g = 0; g < ngroups; g++) begin
        px[31:0]  = $urandom;
        px[39:32] = 8'($urandom);
        send_group(px, (g == ngroups - 1), (g == 0) ? line_mode : 1'($urandom), 1'b1, waits);
        mode_i = 1'($urandom);
        idle($urandom_range(0, 2));
      end
      if ($urandom_range(0, 3) == 0) drain("random_line_drain");
    end
    ready_mode = 2;
    drain("random_final_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
